// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDUSel codes, FSM states, default latencies.
// MADD/MADDU (codes 6/7) are only decoded when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_HI    = 3'd4;
  localparam logic [2:0] MDU_LO    = 3'd5;
  localparam logic [2:0] MDU_MADD  = 3'd6;
  localparam logic [2:0] MDU_MADDU = 3'd7;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the MDU: 64-bit {HI,LO} result for the selected op plus a divide-by-zero flag.
// Accumulate ops (MADD/MADDU) are produced only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] result_o,
  output logic        div_zero_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sdiv;
  logic        rt_zero;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    prod_u = {32'b0, rs_i} * {32'b0, rt_i};
  end

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    sdiv    = (sel_i == MDU_DIV);
    rt_zero = (rt_i == '0);
    mag_a   = (sdiv && rs_i[31]) ? (~rs_i + 32'd1) : rs_i;
    mag_b   = (sdiv && rt_i[31]) ? (~rt_i + 32'd1) : rt_i;
    divisor = rt_zero ? 32'd1 : mag_b;
    quo     = mag_a / divisor;
    rem     = mag_a % divisor;
    quo_fix = (sdiv && (rs_i[31] ^ rt_i[31])) ? (~quo + 32'd1) : quo;
    rem_fix = (sdiv && rs_i[31]) ? (~rem + 32'd1) : rem;
  end

  always_comb begin
    result_o   = {hi_i, lo_i};
    div_zero_o = 1'b0;
    case (sel_i)
      MDU_MULT:  result_o = prod_s;
      MDU_MULTU: result_o = prod_u;
      MDU_DIV, MDU_DIVU: begin
        result_o   = {rem_fix, quo_fix};
        div_zero_o = rt_zero;
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  result_o = {hi_i, lo_i} + prod_s;
      MDU_MADDU: result_o = {hi_i, lo_i} + prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// P6 execute-stage multiply/divide unit: owns HI/LO, models latency with a busy flag, serves mfhi/mflo.
// Define MDU_MADD_EN to enable MADD/MADDU accumulate (sel 6/7).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  sel,
  input  logic        move_to,
  input  logic        move_from,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] rd_data
);

  mdu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] result;
  logic        div_zero;
  logic        op_valid;
  logic [31:0] lat;

  mdu_arith u_arith (
    .sel_i      (sel),
    .rs_i       (rs_data),
    .rt_i       (rt_data),
    .hi_i       (hi_q),
    .lo_i       (lo_q),
    .result_o   (result),
    .div_zero_o (div_zero)
  );

  always_comb begin
    op_valid = 1'b0;
    lat      = '0;
    case (sel)
      MDU_MULT, MDU_MULTU: begin
        op_valid = 1'b1;
        lat      = 32'(MULT_CYCLES);
      end
      MDU_DIV, MDU_DIVU: begin
        op_valid = 1'b1;
        lat      = 32'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: begin
        op_valid = 1'b1;
        lat      = 32'(MULT_CYCLES);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // The result is captured at launch; BUSY only counts down, so operand changes in flight are harmless.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_valid) begin
            pend_d  = result;
            dz_d    = div_zero;
            cnt_d   = lat;
            state_d = S_BUSY;
          end
        end else if (move_to) begin
          if (sel == MDU_HI) hi_d = rs_data;
          if (sel == MDU_LO) lo_d = rs_data;
        end
      end
      S_BUSY: begin
        if (cnt_q == 32'd1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_BUSY);
    rd_data = '0;
    if (move_from) begin
      if (sel == MDU_HI) rd_data = hi_q;
      if (sel == MDU_LO) rd_data = lo_q;
    end
  end

endmodule
